// File: rtl/llc_lookup_pkt_gen_pkg.sv
// Shared LLC lookup types: set/tag/way/state widths and the memory-to-lookup FIFO packet.
// Packet construction helper used by llc_lookup_pkt_gen (optional skid queue: LLC_LOOKUP_SKID_EN).
package llc_lookup_pkt_gen_pkg;
  localparam int LLC_SET_BITS   = 8;
  localparam int LLC_WAYS       = 4;
  localparam int LLC_WAY_BITS   = 2;
  localparam int LLC_TAG_BITS   = 12;
  localparam int LLC_STATE_BITS = 2;

  typedef logic [LLC_TAG_BITS-1:0] llc_tag_t;
  typedef logic [LLC_WAY_BITS-1:0] llc_way_t;

  typedef enum logic [LLC_STATE_BITS-1:0] {
    INVALID  = 2'd0,
    VALID    = 2'd1,
    SHARED   = 2'd2,
    MODIFIED = 2'd3
  } llc_state_t;

  typedef struct packed {
    llc_tag_t                           tag_input;
    logic [LLC_WAYS*LLC_TAG_BITS-1:0]   rd_tags_pipeline;
    logic [LLC_WAYS*LLC_STATE_BITS-1:0] rd_states_pipeline;
    llc_way_t                           rd_evict_way_pipeline;
    logic [LLC_WAYS-1:0]                rd_dirty_pipeline;
    logic [LLC_WAYS-1:0]                rd_sharers_pipeline;
  } fifo_mem_lookup_packet;

  // Fields this producer does not own stay zero for the lookup-way stage.
  function automatic fifo_mem_lookup_packet make_lookup_pkt(
    input llc_tag_t                           tag,
    input logic [LLC_WAYS*LLC_TAG_BITS-1:0]   tags,
    input logic [LLC_WAYS*LLC_STATE_BITS-1:0] states,
    input llc_way_t                           evict_way
  );
    fifo_mem_lookup_packet pkt;
    pkt                       = '0;
    pkt.tag_input             = tag;
    pkt.rd_tags_pipeline      = tags;
    pkt.rd_states_pipeline    = states;
    pkt.rd_evict_way_pipeline = evict_way;
    return pkt;
  endfunction
endpackage

// File: rtl/llc_lookup_pkt_gen_hold_q.sv
// llc_lookup_hold_q: in-order holding queue of captured lookup packets.
// DEPTH==1 collapses to a single entry register without pointers.
module llc_lookup_hold_q #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_head_valid,
  output logic [WIDTH-1:0] o_head_data
);
  if (DEPTH == 1) begin : g_single
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (i_push) begin
        r_valid <= 1'b1;
        r_data  <= i_push_data;
      end else if (i_pop) begin
        r_valid <= 1'b0;
      end
    end

    assign o_head_valid = r_valid;
    assign o_head_data  = r_data;
  end else begin : g_ring
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (i_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
        if (i_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
        r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
    end

    always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head_valid = (r_count != '0);
    assign o_head_data  = r_mem[r_rd_ptr];
  end
endmodule

// File: rtl/llc_lookup_pkt_gen.sv
// llc_lookup_pkt_gen: issues LLC tag/state SRAM reads and pushes one lookup packet per request.
// `LLC_LOOKUP_SKID_EN selects a MEM_RD_LAT+1 deep skid queue for full-rate operation.
module llc_lookup_pkt_gen
  import llc_lookup_pkt_gen_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [LLC_SET_BITS-1:0]            req_set,
  input  llc_tag_t                           req_tag,
  output logic                               rd_mem_en,
  output logic [LLC_SET_BITS-1:0]            rd_set,
  input  logic [LLC_WAYS*LLC_TAG_BITS-1:0]   rd_tags_mem,
  input  logic [LLC_WAYS*LLC_STATE_BITS-1:0] rd_states_mem,
  input  llc_way_t                           rd_evict_way_mem,
  input  logic                               fifo_full_lookup,
  output logic                               fifo_push_lookup,
  output fifo_mem_lookup_packet              fifo_lookup_in
);
`ifdef LLC_LOOKUP_SKID_EN
  localparam int DEPTH = MEM_RD_LAT + 1;
`else
  localparam int DEPTH = 1;
`endif
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                  w_accept;
  logic                  w_push;
  logic                  w_head_valid;
  fifo_mem_lookup_packet w_head_pkt;
  fifo_mem_lookup_packet w_cap_pkt;
  logic [OCC_W-1:0]      r_occ;

  // occ covers in-flight reads too, so the queue can never be asked to overfill.
  assign w_push           = w_head_valid && !fifo_full_lookup;
  assign req_ready        = (r_occ < OCC_W'(DEPTH)) || w_push;
  assign w_accept         = rst && req_valid && req_ready;
  assign rd_mem_en        = w_accept;
  assign rd_set           = w_accept ? req_set : '0;
  assign fifo_push_lookup = w_push;
  assign fifo_lookup_in   = w_head_valid ? w_head_pkt : '0;

  logic     r_pipe_vld [MEM_RD_LAT];
  llc_tag_t r_pipe_tag [MEM_RD_LAT];
  logic     w_stage_vld_in [MEM_RD_LAT];
  llc_tag_t w_stage_tag_in [MEM_RD_LAT];

  for (genvar gi = 0; gi < MEM_RD_LAT; gi++) begin : g_pipe
    if (gi == 0) begin : g_first
      assign w_stage_vld_in[gi] = w_accept;
      assign w_stage_tag_in[gi] = req_tag;
    end else begin : g_next
      assign w_stage_vld_in[gi] = r_pipe_vld[gi-1];
      assign w_stage_tag_in[gi] = r_pipe_tag[gi-1];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_pipe_vld[gi] <= 1'b0;
        r_pipe_tag[gi] <= '0;
      end else begin
        r_pipe_vld[gi] <= w_stage_vld_in[gi];
        r_pipe_tag[gi] <= w_stage_tag_in[gi];
      end
    end
  end

  // SRAM outputs are only meaningful in the cycle the last stage is valid.
  assign w_cap_pkt = make_lookup_pkt(r_pipe_tag[MEM_RD_LAT-1], rd_tags_mem,
                                     rd_states_mem, rd_evict_way_mem);

  llc_lookup_hold_q #(
    .WIDTH ($bits(fifo_mem_lookup_packet)),
    .DEPTH (DEPTH)
  ) u_hold_q (
    .clk          (clk),
    .rst          (rst),
    .i_push       (r_pipe_vld[MEM_RD_LAT-1]),
    .i_push_data  (w_cap_pkt),
    .i_pop        (w_push),
    .o_head_valid (w_head_valid),
    .o_head_data  (w_head_pkt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ <= '0;
    end else if (w_accept && !w_push) begin
      r_occ <= r_occ + 1'b1;
    end else if (!w_accept && w_push) begin
      r_occ <= r_occ - 1'b1;
    end
  end
endmodule

// File: tb/tb_llc_lookup_pkt_gen.sv
// Bench for llc_lookup_pkt_gen: MEM_RD_LAT=1 and MEM_RD_LAT=2 instances share stimulus and
// are checked every cycle against an in-order request-list model (LLC_LOOKUP_SKID_EN aware).
module tb_llc_lookup_pkt_gen;
  import llc_lookup_pkt_gen_pkg::*;

  logic                               clk = 1'b0;
  logic                               rst = 1'b0;
  logic                               req_valid = 1'b0;
  logic [LLC_SET_BITS-1:0]            req_set = '0;
  llc_tag_t                           req_tag = '0;
  logic [LLC_WAYS*LLC_TAG_BITS-1:0]   rd_tags_mem = '0;
  logic [LLC_WAYS*LLC_STATE_BITS-1:0] rd_states_mem = '0;
  llc_way_t                           rd_evict_way_mem = '0;
  logic                               fifo_full = 1'b0;

  logic                    o_rdy  [2];
  logic                    o_en   [2];
  logic [LLC_SET_BITS-1:0] o_set  [2];
  logic                    o_push [2];
  fifo_mem_lookup_packet   o_pkt  [2];

  always #5 clk = ~clk;

  llc_lookup_pkt_gen #(.MEM_RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_rdy[0]),
    .req_set(req_set), .req_tag(req_tag), .rd_mem_en(o_en[0]), .rd_set(o_set[0]),
    .rd_tags_mem(rd_tags_mem), .rd_states_mem(rd_states_mem),
    .rd_evict_way_mem(rd_evict_way_mem), .fifo_full_lookup(fifo_full),
    .fifo_push_lookup(o_push[0]), .fifo_lookup_in(o_pkt[0])
  );

  llc_lookup_pkt_gen #(.MEM_RD_LAT(2)) u_dut_lat2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(o_rdy[1]),
    .req_set(req_set), .req_tag(req_tag), .rd_mem_en(o_en[1]), .rd_set(o_set[1]),
    .rd_tags_mem(rd_tags_mem), .rd_states_mem(rd_states_mem),
    .rd_evict_way_mem(rd_evict_way_mem), .fifo_full_lookup(fifo_full),
    .fifo_push_lookup(o_push[1]), .fifo_lookup_in(o_pkt[1])
  );

  // Model: list of accepted requests in order, each captured LAT cycles after its accept.
  typedef struct packed {
    llc_tag_t              tag;
    int                    acc;
    bit                    cap;
    fifo_mem_lookup_packet pkt;
  } ent_t;

  ent_t                    m_q [2][4];
  int                      m_n [2];
  int                      cyc = 0;
  int                      n_cmp = 0;
  int                      n_err = 0;
  logic                    exp_rdy  [2];
  logic                    exp_en   [2];
  logic [LLC_SET_BITS-1:0] exp_set  [2];
  logic                    exp_push [2];
  fifo_mem_lookup_packet   exp_pkt  [2];

  function automatic int lat_of(input int k);
    return k + 1;
  endfunction

  function automatic int depth_of(input int k);
`ifdef LLC_LOOKUP_SKID_EN
    return k + 2;
`else
    return (k >= 0) ? 1 : 1;
`endif
  endfunction

  task automatic rand_mem();
    rd_tags_mem      = {16'($urandom()), 32'($urandom())};
    rd_states_mem    = 8'($urandom());
    rd_evict_way_mem = 2'($urandom());
  endtask

  task automatic model_eval();
    for (int k = 0; k < 2; k++) begin
      bit head;
      head = (m_n[k] > 0) && m_q[k][0].cap;
      if (!rst) begin
        exp_push[k] = 1'b0; exp_rdy[k] = 1'b1; exp_en[k] = 1'b0;
        exp_set[k]  = '0;   exp_pkt[k] = '0;
      end else begin
        exp_push[k] = head && !fifo_full;
        exp_rdy[k]  = (m_n[k] < depth_of(k)) || exp_push[k];
        exp_en[k]   = req_valid && exp_rdy[k];
        exp_set[k]  = exp_en[k] ? req_set : '0;
        exp_pkt[k]  = head ? m_q[k][0].pkt : '0;
      end
    end
  endtask

  task automatic model_commit();
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_n[k] = 0;
      end else begin
        if (exp_push[k]) begin
          for (int i = 0; i < 3; i++) m_q[k][i] = m_q[k][i+1];
          m_n[k]--;
        end
        for (int i = 0; i < m_n[k]; i++) begin
          if (!m_q[k][i].cap && (m_q[k][i].acc + lat_of(k) == cyc)) begin
            m_q[k][i].cap = 1'b1;
            m_q[k][i].pkt = '0;
            m_q[k][i].pkt.tag_input             = m_q[k][i].tag;
            m_q[k][i].pkt.rd_tags_pipeline      = rd_tags_mem;
            m_q[k][i].pkt.rd_states_pipeline    = rd_states_mem;
            m_q[k][i].pkt.rd_evict_way_pipeline = rd_evict_way_mem;
          end
        end
        if (exp_en[k]) begin
          m_q[k][m_n[k]] = '{tag: req_tag, acc: cyc, cap: 1'b0, pkt: '0};
          m_n[k]++;
        end
      end
    end
    cyc++;
  endtask

  task automatic begin_cycle();
    model_eval();
    @(negedge clk);
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    req_set   = 8'hAB;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp += 5;
      if (o_rdy[k] !== 1'b1) begin n_err++; $display("FAIL reset.ready lat%0d: got %b want 1", k+1, o_rdy[k]); end
      if (o_en[k] !== 1'b0) begin n_err++; $display("FAIL reset.rd_mem_en lat%0d: got %b want 0", k+1, o_en[k]); end
      if (o_set[k] !== 8'h00) begin n_err++; $display("FAIL reset.rd_set lat%0d: got %h want 00", k+1, o_set[k]); end
      if (o_push[k] !== 1'b0) begin n_err++; $display("FAIL reset.push lat%0d: got %b want 0", k+1, o_push[k]); end
      if (o_pkt[k] !== '0) begin n_err++; $display("FAIL reset.pkt lat%0d: got %h want 0", k+1, o_pkt[k]); end
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [LLC_WAYS*LLC_STATE_BITS-1:0] st;
    st = {MODIFIED, SHARED, INVALID, VALID};
    for (int c = 0; c < 6; c++) begin
      req_valid = (c == 0); req_set = 8'h12; req_tag = 12'h3A5; fifo_full = 1'b0;
      rand_mem();
      if (c == 1) begin
        rd_tags_mem = 48'h3A5_111_222_333; rd_states_mem = st; rd_evict_way_mem = 2'd2;
      end
      begin_cycle();
      for (int k = 0; k < 2; k++) begin
        n_cmp += 5;
        if (o_rdy[k] !== exp_rdy[k]) begin n_err++; $display("FAIL single.ready lat%0d cyc %0d: got %b want %b", k+1, cyc, o_rdy[k], exp_rdy[k]); end
        if (o_en[k] !== exp_en[k]) begin n_err++; $display("FAIL single.rd_mem_en lat%0d cyc %0d: got %b want %b", k+1, cyc, o_en[k], exp_en[k]); end
        if (o_set[k] !== exp_set[k]) begin n_err++; $display("FAIL single.rd_set lat%0d cyc %0d: got %h want %h", k+1, cyc, o_set[k], exp_set[k]); end
        if (o_push[k] !== exp_push[k]) begin n_err++; $display("FAIL single.push lat%0d cyc %0d: got %b want %b", k+1, cyc, o_push[k], exp_push[k]); end
        if (o_pkt[k] !== exp_pkt[k]) begin n_err++; $display("FAIL single.pkt lat%0d cyc %0d: got %h want %h", k+1, cyc, o_pkt[k], exp_pkt[k]); end
        if (o_push[k] === 1'b1) $display("lat%0d cyc %0d push tag=%03h", k+1, cyc, o_pkt[k].tag_input);
      end
      if (c == 0) begin
        n_cmp++;
        if (o_en[0] !== 1'b1 || o_set[0] !== 8'h12) begin n_err++; $display("FAIL single.issue: got en=%b set=%h want en=1 set=12", o_en[0], o_set[0]); end
      end
      if (c == 2) begin
        n_cmp++;
        if (o_push[0] !== 1'b1 || o_pkt[0].tag_input !== 12'h3A5 || o_pkt[0].rd_tags_pipeline !== 48'h3A5_111_222_333
            || o_pkt[0].rd_states_pipeline !== st || o_pkt[0].rd_evict_way_pipeline !== 2'd2) begin
          n_err++; $display("FAIL single.push_pkt: got push=%b pkt=%h want push=1 tag=3a5 states=%h evict=2", o_push[0], o_pkt[0], st);
        end
      end
      end_cycle();
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int pushes = 0;
    for (int c = 0; c < 80 && pushes < 8; c++) begin
      req_valid = (acc < 8); req_tag = 12'(acc); req_set = 8'(acc + 8'h40); fifo_full = 1'b0;
      rand_mem();
      begin_cycle();
      for (int k = 0; k < 2; k++) begin
        n_cmp += 5;
        if (o_rdy[k] !== exp_rdy[k]) begin n_err++; $display("FAIL b2b.ready lat%0d cyc %0d: got %b want %b", k+1, cyc, o_rdy[k], exp_rdy[k]); end
        if (o_en[k] !== exp_en[k]) begin n_err++; $display("FAIL b2b.rd_mem_en lat%0d cyc %0d: got %b want %b", k+1, cyc, o_en[k], exp_en[k]); end
        if (o_set[k] !== exp_set[k]) begin n_err++; $display("FAIL b2b.rd_set lat%0d cyc %0d: got %h want %h", k+1, cyc, o_set[k], exp_set[k]); end
        if (o_push[k] !== exp_push[k]) begin n_err++; $display("FAIL b2b.push lat%0d cyc %0d: got %b want %b", k+1, cyc, o_push[k], exp_push[k]); end
        if (o_pkt[k] !== exp_pkt[k]) begin n_err++; $display("FAIL b2b.pkt lat%0d cyc %0d: got %h want %h", k+1, cyc, o_pkt[k], exp_pkt[k]); end
        if (o_push[k] === 1'b1) $display("lat%0d cyc %0d push tag=%03h", k+1, cyc, o_pkt[k].tag_input);
      end
      if (o_en[1] === 1'b1) acc++;
      if (o_push[1] === 1'b1) begin
        n_cmp++;
        if (o_pkt[1].tag_input !== 12'(pushes)) begin n_err++; $display("FAIL b2b.order: got tag %03h want %03h", o_pkt[1].tag_input, 12'(pushes)); end
        pushes++;
      end
      end_cycle();
    end
    n_cmp++;
    if (pushes != 8) begin n_err++; $display("FAIL b2b.count: got %0d pushes want 8", pushes); end
    req_valid = 1'b0;
    repeat (4) begin begin_cycle(); end_cycle(); end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 20; c++) begin
      req_valid = (c < 10); req_tag = 12'($urandom()); req_set = 8'($urandom()); fifo_full = (c < 10);
      rand_mem();
      begin_cycle();
      for (int k = 0; k < 2; k++) begin
        n_cmp += 5;
        if (o_rdy[k] !== exp_rdy[k]) begin n_err++; $display("FAIL bp.ready lat%0d cyc %0d: got %b want %b", k+1, cyc, o_rdy[k], exp_rdy[k]); end
        if (o_en[k] !== exp_en[k]) begin n_err++; $display("FAIL bp.rd_mem_en lat%0d cyc %0d: got %b want %b", k+1, cyc, o_en[k], exp_en[k]); end
        if (o_set[k] !== exp_set[k]) begin n_err++; $display("FAIL bp.rd_set lat%0d cyc %0d: got %h want %h", k+1, cyc, o_set[k], exp_set[k]); end
        if (o_push[k] !== exp_push[k]) begin n_err++; $display("FAIL bp.push lat%0d cyc %0d: got %b want %b", k+1, cyc, o_push[k], exp_push[k]); end
        if (o_pkt[k] !== exp_pkt[k]) begin n_err++; $display("FAIL bp.pkt lat%0d cyc %0d: got %h want %h", k+1, cyc, o_pkt[k], exp_pkt[k]); end
        if (o_push[k] === 1'b1) $display("lat%0d cyc %0d push tag=%03h", k+1, cyc, o_pkt[k].tag_input);
      end
      if (c == 10) begin
        n_cmp++;
        if (o_rdy[1] !== 1'b1 || o_push[1] !== 1'b1) begin n_err++; $display("FAIL bp.release: got ready=%b push=%b want 1 1", o_rdy[1], o_push[1]); end
      end
      end_cycle();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (c == 203) rst = 1'b1;
      req_valid = ($urandom_range(0, 9) < 7); req_tag = 12'($urandom()); req_set = 8'($urandom());
      fifo_full = ($urandom_range(0, 9) < 3);
      rand_mem();
      begin_cycle();
      for (int k = 0; k < 2; k++) begin
        n_cmp += 5;
        if (o_rdy[k] !== exp_rdy[k]) begin n_err++; $display("FAIL rand.ready lat%0d cyc %0d: got %b want %b", k+1, cyc, o_rdy[k], exp_rdy[k]); end
        if (o_en[k] !== exp_en[k]) begin n_err++; $display("FAIL rand.rd_mem_en lat%0d cyc %0d: got %b want %b", k+1, cyc, o_en[k], exp_en[k]); end
        if (o_set[k] !== exp_set[k]) begin n_err++; $display("FAIL rand.rd_set lat%0d cyc %0d: got %h want %h", k+1, cyc, o_set[k], exp_set[k]); end
        if (o_push[k] !== exp_push[k]) begin n_err++; $display("FAIL rand.push lat%0d cyc %0d: got %b want %b", k+1, cyc, o_push[k], exp_push[k]); end
        if (o_pkt[k] !== exp_pkt[k]) begin n_err++; $display("FAIL rand.pkt lat%0d cyc %0d: got %h want %h", k+1, cyc, o_pkt[k], exp_pkt[k]); end
        if (o_push[k] === 1'b1) $display("lat%0d cyc %0d push tag=%03h", k+1, cyc, o_pkt[k].tag_input);
      end
      end_cycle();
      if (c == 199) begin
        // Mid-operation reset: outputs must fall back without waiting for a clock edge.
        req_valid = 1'b1; fifo_full = 1'b1;
        rst = 1'b0;
        m_n[0] = 0; m_n[1] = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
          n_cmp += 4;
          if (o_rdy[k] !== 1'b1) begin n_err++; $display("FAIL arst.ready lat%0d: got %b want 1", k+1, o_rdy[k]); end
          if (o_en[k] !== 1'b0) begin n_err++; $display("FAIL arst.rd_mem_en lat%0d: got %b want 0", k+1, o_en[k]); end
          if (o_push[k] !== 1'b0) begin n_err++; $display("FAIL arst.push lat%0d: got %b want 0", k+1, o_push[k]); end
          if (o_pkt[k] !== '0) begin n_err++; $display("FAIL arst.pkt lat%0d: got %h want 0", k+1, o_pkt[k]); end
        end
      end
    end
  endtask

  initial begin
    m_n[0] = 0;
    m_n[1] = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
